// File: rtl/ibex_fetch_align_fifo_pkg.sv
// Shared types and constants for the fetch alignment FIFO.
// Each buffered fetch response is stored as a word plus its bus-error flag.
package ibex_fetch_align_fifo_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned HALF_W  = 16;

   localparam logic [31:0] PC_STEP_C = 32'd2;
   localparam logic [31:0] PC_STEP_U = 32'd4;

   typedef struct packed {
      logic [INSTR_W-1:0] word;
      logic               err;
   } fifo_entry_t;

endpackage

// File: rtl/ibex_fetch_align_fifo.sv
// Fetch buffer: queues word-aligned fetch responses and presents one aligned
// instruction (compressed, aligned or unaligned uncompressed) per cycle with its PC.
module ibex_fetch_align_fifo
   import ibex_fetch_align_fifo_pkg::*;
#(
   parameter int unsigned DEPTH    = 3,
   parameter logic [31:0] BootAddr = 32'h0000_0080
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        in_valid_i,
   input  logic [31:0] in_rdata_i,
   input  logic        in_err_i,
   output logic        busy_o,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_rdata_o,
   output logic [31:0] out_pc_o,
   output logic        out_err_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_BUSY = CNT_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

   fifo_entry_t      mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [31:0]      pc_q;

   fifo_entry_t      head, next;
   logic [15:0]      head_hi, head_lo;
   logic             has_head, has_next;
   logic             pop, pop_en, push_en, transfer;
   logic [31:0]      pc_step;
   logic             unused_pc_bit;

   function automatic logic is_compressed(input logic [15:0] h);
      return h[1:0] != 2'b11;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_MAX) ? '0 : p + PTR_W'(1);
   endfunction

   assign unused_pc_bit = redirect_pc_i[0];

   assign head     = mem_q[rd_ptr_q];
   assign next     = mem_q[ptr_inc(rd_ptr_q)];
   assign head_hi  = head.word[31:16];
   assign head_lo  = head.word[15:0];
   assign has_head = (count_q != '0);
   assign has_next = (count_q >= CNT_TWO);

   always_comb begin
      out_valid_o = 1'b0;
      out_rdata_o = '0;
      out_err_o   = 1'b0;
      pop         = 1'b0;
      pc_step     = PC_STEP_U;
      if (has_head) begin
         if (!pc_q[1]) begin
            out_valid_o = 1'b1;
            out_err_o   = head.err;
            if (is_compressed(head_lo)) begin
               out_rdata_o = {16'h0, head_lo};
               pc_step     = PC_STEP_C;
            end else begin
               out_rdata_o = head.word;
               pop         = 1'b1;
            end
         end else if (is_compressed(head_hi)) begin
            out_valid_o = 1'b1;
            out_rdata_o = {16'h0, head_hi};
            out_err_o   = head.err;
            pop         = 1'b1;
            pc_step     = PC_STEP_C;
         end else if (head.err) begin
            // Errored head is reported at once; the upper half is never filled,
            // which keeps the output stable if the next word arrives while stalled.
            out_valid_o = 1'b1;
            out_rdata_o = {16'h0, head_hi};
            out_err_o   = 1'b1;
            pop         = 1'b1;
         end else if (has_next) begin
            out_valid_o = 1'b1;
            out_rdata_o = {next.word[15:0], head_hi};
            out_err_o   = next.err;
            pop         = 1'b1;
         end
      end
   end

   assign transfer = out_valid_o & out_ready_i;
   assign pop_en   = transfer & pop;
   assign push_en  = in_valid_i;
   assign busy_o   = (count_q >= CNT_BUSY);
   assign out_pc_o = pc_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         pc_q     <= BootAddr;
      end else if (clear_i) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         pc_q     <= {redirect_pc_i[31:1], 1'b0};
      end else begin
         if (push_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop_en)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (transfer) pc_q <= pc_q + pc_step;
         case ({push_en, pop_en})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked solely by count_q.
   always_ff @(posedge clk_i) begin
      if (push_en && !clear_i) begin
         mem_q[wr_ptr_q] <= fifo_entry_t'{word: in_rdata_i, err: in_err_i};
      end
   end

`ifndef SYNTHESIS
   a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (out_valid_o && !out_ready_i && !clear_i) |=>
      (out_valid_o && $stable(out_rdata_o) && $stable(out_pc_o) && $stable(out_err_o)));

   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (in_valid_i && !clear_i && count_q == CNT_FULL) |-> pop_en);

   a_depth_range: assert property (@(posedge clk_i) (DEPTH >= 2) && (DEPTH <= 8));
`endif

endmodule

// File: tb/tb_ibex_fetch_align_fifo.sv
// Bench for ibex_fetch_align_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ibex_fetch_align_fifo;

   localparam int unsigned DEPTH = 3;
   localparam logic [31:0] BOOT  = 32'h0000_0080;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        in_valid = 1'b0;
   logic [31:0] in_rdata = '0;
   logic        in_err = 1'b0;
   logic        out_ready = 1'b0;
   logic        busy, out_valid, out_err;
   logic [31:0] out_rdata, out_pc;

   ibex_fetch_align_fifo #(.DEPTH(DEPTH), .BootAddr(BOOT)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .clear_i      (clear),
      .redirect_pc_i(redirect_pc),
      .in_valid_i   (in_valid),
      .in_rdata_i   (in_rdata),
      .in_err_i     (in_err),
      .busy_o       (busy),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .out_rdata_o  (out_rdata),
      .out_pc_o     (out_pc),
      .out_err_o    (out_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: list of {err, word} plus the fetch PC.
   logic [32:0] m_q[$];
   logic [31:0] m_pc = BOOT;

   function automatic void model_out(output logic v, output logic [31:0] d, output logic e,
                                     output logic pop, output logic [31:0] len);
      logic [31:0] w;
      logic [15:0] half;
      v = 1'b0; d = '0; e = 1'b0; pop = 1'b0; len = 32'd4;
      if (m_q.size() == 0) return;
      w    = m_q[0][31:0];
      half = m_pc[1] ? w[31:16] : w[15:0];
      if (half[1:0] != 2'b11) begin
         v = 1'b1; d = {16'h0, half}; e = m_q[0][32]; pop = m_pc[1]; len = 32'd2;
      end else if (!m_pc[1]) begin
         v = 1'b1; d = w; e = m_q[0][32]; pop = 1'b1;
      end else if (m_q[0][32]) begin
         v = 1'b1; d = {16'h0, half}; e = 1'b1; pop = 1'b1;
      end else if (m_q.size() >= 2) begin
         v = 1'b1; d = {m_q[1][15:0], half}; e = m_q[1][32]; pop = 1'b1;
      end
   endfunction

   always @(posedge clk or negedge rst_n) begin
      logic v, e, pop;
      logic [31:0] d, len;
      if (!rst_n) begin
         m_q.delete();
         m_pc = BOOT;
      end else if (clear) begin
         m_q.delete();
         m_pc = {redirect_pc[31:1], 1'b0};
      end else begin
         model_out(v, d, e, pop, len);
         if (v && out_ready) begin
            m_pc = m_pc + len;
            if (pop) void'(m_q.pop_front());
         end
         if (in_valid) m_q.push_back({in_err, in_rdata});
      end
   end

   always @(negedge clk) begin
      logic v, e, pop;
      logic [31:0] d, len;
      model_out(v, d, e, pop, len);
      check("model valid", {31'h0, out_valid}, {31'h0, v});
      check("model rdata", out_rdata, d);
      check("model err",   {31'h0, out_err}, {31'h0, e});
      check("model pc",    out_pc, m_pc);
      check("model busy",  {31'h0, busy}, {31'h0, (m_q.size() >= DEPTH - 1)});
   end

   task automatic tick(input logic c, input logic [31:0] rpc, input logic v,
                       input logic [31:0] d, input logic e, input logic r);
      clear = c; redirect_pc = rpc; in_valid = v; in_rdata = d; in_err = e; out_ready = r;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input logic r);
      tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, r);
   endtask

   task automatic push(input logic [31:0] d, input logic e, input logic r);
      tick(1'b0, 32'h0, 1'b1, d, e, r);
   endtask

   task automatic redirect(input logic [31:0] pc);
      tick(1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("reset valid", {31'h0, out_valid}, 32'h0);
      check("reset busy",  {31'h0, busy}, 32'h0);
      check("reset pc",    out_pc, BOOT);
      check("reset rdata", out_rdata, 32'h0);
      rst_n = 1'b1;

      // aligned uncompressed
      redirect(32'h100);
      push(32'h00A00513, 1'b0, 1'b0);
      check("t1 valid", {31'h0, out_valid}, 32'h1);
      check("t1 rdata", out_rdata, 32'h00A00513);
      check("t1 pc", out_pc, 32'h100);
      idle(1'b1);
      check("t1 empty", {31'h0, out_valid}, 32'h0);
      check("t1 pc after", out_pc, 32'h104);

      // two compressed halves of one word
      redirect(32'h100);
      push(32'h45854505, 1'b0, 1'b0);
      check("t2 lo rdata", out_rdata, 32'h00004505);
      check("t2 lo pc", out_pc, 32'h100);
      idle(1'b1);
      check("t2 hi valid", {31'h0, out_valid}, 32'h1);
      check("t2 hi rdata", out_rdata, 32'h00004585);
      check("t2 hi pc", out_pc, 32'h102);
      idle(1'b1);
      check("t2 popped", {31'h0, out_valid}, 32'h0);
      check("t2 pc after", out_pc, 32'h104);

      // unaligned uncompressed across two words
      redirect(32'h102);
      push(32'h05130001, 1'b0, 1'b0);
      check("t3 wait", {31'h0, out_valid}, 32'h0);
      push(32'h000000A0, 1'b0, 1'b0);
      check("t3 valid", {31'h0, out_valid}, 32'h1);
      check("t3 rdata", out_rdata, 32'h00A00513);
      check("t3 pc", out_pc, 32'h102);
      check("t3 err", {31'h0, out_err}, 32'h0);
      idle(1'b1);
      check("t3 pc after", out_pc, 32'h106);
      idle(1'b1);
      check("t3 drained pc", out_pc, 32'h108);

      // error on the second word of a spanning instruction
      redirect(32'h102);
      push(32'h05130001, 1'b0, 1'b0);
      push(32'h000000A0, 1'b1, 1'b0);
      check("t3b err", {31'h0, out_err}, 32'h1);
      redirect(32'h102);

      // errored head does not wait for the next word
      push(32'h05130001, 1'b1, 1'b0);
      check("t4 valid", {31'h0, out_valid}, 32'h1);
      check("t4 err", {31'h0, out_err}, 32'h1);
      check("t4 pc", out_pc, 32'h102);
      idle(1'b1);
      check("t4 done", {31'h0, out_valid}, 32'h0);
      check("t4 pc after", out_pc, 32'h106);

      // fill to full, push+pop at full
      redirect(32'h300);
      push(32'h00000013, 1'b0, 1'b0);
      check("t5 busy1", {31'h0, busy}, 32'h0);
      push(32'h00100093, 1'b0, 1'b0);
      check("t5 busy2", {31'h0, busy}, 32'h1);
      push(32'h00200113, 1'b0, 1'b0);
      check("t5 full head", out_rdata, 32'h00000013);
      push(32'h00300193, 1'b0, 1'b1);
      check("t5 pushpop rdata", out_rdata, 32'h00100093);
      check("t5 pushpop pc", out_pc, 32'h304);
      check("t5 pushpop busy", {31'h0, busy}, 32'h1);
      idle(1'b1);
      check("t5 order", out_rdata, 32'h00200113);
      check("t5 order pc", out_pc, 32'h308);
      push(32'h00400213, 1'b0, 1'b0);

      // clear at full discards same-cycle push and transfer
      tick(1'b1, 32'h200, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
      check("t6 valid", {31'h0, out_valid}, 32'h0);
      check("t6 busy", {31'h0, busy}, 32'h0);
      check("t6 pc", out_pc, 32'h200);
      idle(1'b0);
      check("t6 still empty", {31'h0, out_valid}, 32'h0);
      push(32'h00A00513, 1'b0, 1'b0);
      check("t6 next word", out_rdata, 32'h00A00513);
      idle(1'b1);
      check("t6 pc after", out_pc, 32'h204);

      // PC wrap-around with odd redirect bit
      redirect(32'hFFFF_FFFF);
      check("wrap pc", out_pc, 32'hFFFF_FFFE);
      push(32'h00010001, 1'b0, 1'b0);
      check("wrap rdata", out_rdata, 32'h00000001);
      idle(1'b1);
      check("wrap pc after", out_pc, 32'h0);

      // asynchronous reset mid-operation
      redirect(32'h100);
      push(32'h00A00513, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("areset valid", {31'h0, out_valid}, 32'h0);
      check("areset pc", out_pc, BOOT);
      check("areset rdata", out_rdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1'b1);
      check("areset stays empty", {31'h0, out_valid}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
